// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types, defaults and the brightness scaler for the
//               WS2812B pixel fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int DEF_PIXELS     = 64;
    localparam int DEF_FRAMES     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Wire order of a WS2812B word: green first, then red, then blue.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // (c * (br + 1)) >> 8 : br = 255 is the identity, br = 0 is black.
    function automatic logic [7:0] scale_byte(input logic [7:0] c,
                                              input logic [7:0] br);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, br} + 17'd1);
        return 8'(prod >> 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fetch_if
// Description : valid/ready stream of finished GRB words towards the
//               serializer loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_fetch_if;
    import led_pkg::*;

    grb_t pix_data;
    logic pix_valid;
    logic pix_ready;

    modport master (output pix_data, output pix_valid, input  pix_ready);
    modport slave  (input  pix_data, input  pix_valid, output pix_ready);

endinterface
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy
//               count. The head entry is always visible on data_o.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic      [AW:0]      count_o,
    output logic                  empty_o
);

    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (count_q == '0);
    assign w_pop   = pop_i && !empty_o;
    // A full FIFO only accepts a write in the same cycle as a read.
    assign w_push  = push_i && ((count_q != C_FULL) || w_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; entries cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fetch
// Description : Walks the pixels of one animation frame through the colour
//               memories, scales and masks each pixel, and queues GRB words
//               for the serializer loader.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fetch
    import led_pkg::*;
#(
    parameter int PIXELS     = DEF_PIXELS,
    parameter int FRAMES     = DEF_FRAMES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  wire logic                                    clk,
    input  wire logic                                    rst,
    input  wire logic                                    start_i,
    input  wire logic [$clog2(FRAMES)-1:0]               frame_i,
    input  wire logic [7:0]                              brightness_i,
    input  wire logic [2:0]                              channel_mask_i,
    output logic [$clog2(FRAMES)+$clog2(PIXELS)-1:0]     mem_addr_o,
    input  wire logic [7:0]                              red_data_i,
    input  wire logic [7:0]                              green_data_i,
    input  wire logic [7:0]                              blue_data_i,
    output logic                                         busy_o,
    output logic                                         frame_done_o,
    pixel_fetch_if.master                                pix
);

    localparam int PIX_W = $clog2(PIXELS);
    localparam int FRM_W = $clog2(FRAMES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0]       S_IDLE  = IDLE;
    localparam logic [1:0]       S_FETCH = FETCH;
    localparam logic [1:0]       S_DRAIN = DRAIN;
    localparam logic [PIX_W-1:0] C_LAST  = PIX_W'(PIXELS - 1);
    localparam logic [CNT_W:0]   C_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

    logic [1:0]             state_q,  state_d;
    logic [FRM_W-1:0]       frame_q,  frame_d;
    logic [7:0]             bright_q, bright_d;
    logic [2:0]             mask_q,   mask_d;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;   // next pixel to issue
    logic [PIX_W-1:0]       out_cnt_q, out_cnt_d;   // pixels already transferred
    logic [FRM_W+PIX_W-1:0] addr_q,   addr_d;
    logic                   a_vld_q,  a_vld_d;
    logic                   b_vld_q;
    logic                   done_q,   done_d;

    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_empty;
    logic [23:0]            w_fifo_data;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_credit;
    grb_t                   w_word;

    assign w_push = b_vld_q;
    assign w_pop  = pix.pix_valid && pix.pix_ready;

    // Issue only if every word already in flight still has a FIFO slot waiting for it.
    assign w_credit = ((CNT_W + 1)'(w_fifo_count) + (CNT_W + 1)'(a_vld_q)
                       + (CNT_W + 1)'(b_vld_q)) < C_DEPTH;

    // Scale each channel, then zero the bytes whose mask bit is clear.
    always_comb begin
        w_word.g = mask_q[2] ? scale_byte(green_data_i, bright_q) : 8'd0;
        w_word.r = mask_q[1] ? scale_byte(red_data_i,   bright_q) : 8'd0;
        w_word.b = mask_q[0] ? scale_byte(blue_data_i,  bright_q) : 8'd0;
    end

    // Frame sequencer: pixel 0 is issued on the start edge, then one per credit.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bright_d  = bright_q;
        mask_d    = mask_q;
        pix_cnt_d = pix_cnt_q;
        out_cnt_d = out_cnt_q;
        addr_d    = addr_q;
        a_vld_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    frame_d   = frame_i;
                    bright_d  = brightness_i;
                    mask_d    = channel_mask_i;
                    addr_d    = {frame_i, {PIX_W{1'b0}}};
                    a_vld_d   = 1'b1;
                    pix_cnt_d = PIX_W'(1);
                    out_cnt_d = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_pop) begin
                    out_cnt_d = out_cnt_q + PIX_W'(1);
                end
                if (w_credit) begin
                    addr_d    = {frame_q, pix_cnt_q};
                    a_vld_d   = 1'b1;
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    if (pix_cnt_q == C_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop) begin
                    out_cnt_d = out_cnt_q + PIX_W'(1);
                    if (out_cnt_q == C_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, stage A address/valid and stage B valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bright_q  <= '0;
            mask_q    <= '0;
            pix_cnt_q <= '0;
            out_cnt_q <= '0;
            addr_q    <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bright_q  <= bright_d;
            mask_q    <= mask_d;
            pix_cnt_q <= pix_cnt_d;
            out_cnt_q <= out_cnt_d;
            addr_q    <= addr_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= a_vld_q;
            done_q    <= done_d;
        end
    end

    pixel_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_word),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .count_o (w_fifo_count),
        .empty_o (w_fifo_empty)
    );

    assign mem_addr_o    = addr_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = done_q;
    assign pix.pix_valid = !w_fifo_empty;
    assign pix.pix_data  = w_fifo_data;

endmodule
`default_nettype wire

// File: doc/pixel_fetch.md
# pixel_fetch

Upstream feeder for the WS2812B serializer path. On a frame start it walks the 64 pixels of the selected animation frame and issues reads to the three synchronous colour memories (red, green, blue; 1-cycle read latency). It applies a channel mask and a global brightness scale, then queues finished 24-bit GRB words in a 4-deep FIFO. Words are presented on a valid/ready handshake to the stage that loads the serializer shift register.

## Interface
- PIXELS, 64: pixels per frame; the pixel index is 6 bits.
- FRAMES, 32: frames in memory; the frame index is 5 bits.
- FIFO_DEPTH, 4: output queue entries, power of two.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to fetch a frame; honoured only in IDLE.
- frame  in  5  frame index, sampled with start.
- brightness  in  8  global scale, sampled with start.
- channel_mask  in  3  {G,R,B} enables, sampled with start; a 0 bit forces that byte to 0.
- mem_addr  out  11  registered read address {frame, pixel}.
- red_data, green_data, blue_data  in  8 each  memory read data, valid 1 cycle after mem_addr.
- pix_data  out  24  {G,R,B} head-of-FIFO word.
- pix_valid  out  1  FIFO non-empty.
- pix_ready  in  1  consumer accepts; a transfer happens when pix_valid && pix_ready.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame transfers.

## Operation
- FSM states:
  - IDLE: wait for start. On start, latch frame, brightness and mask, clear the pixel counter, and go to FETCH. start outside IDLE is ignored.
  - FETCH: issue one address per cycle while fifo_count + inflight < FIFO_DEPTH. inflight is the count of valid bits across the address and data stages, 0–2. After pixel PIXELS-1 is issued, go to DRAIN.
  - DRAIN: no new issues. When the word for pixel PIXELS-1 transfers, pulse frame_done and go to IDLE.
- Pipeline:
  - Stage A: mem_addr register plus its valid bit.
  - Stage B: memory output plus its valid bit.
  - The scaled word is written into the FIFO at the edge ending stage B.
- Scaling, per channel: out = (c × (brightness+1)) >> 8.
  - The product is 9b×8b → 17b; keep bits [15:8].
  - brightness=255 passes c through unchanged; brightness=0 gives 0.
  - The mask is applied after scaling.
- FIFO: synchronous, first-word-fall-through (pix_data = head). A simultaneous push and pop keeps the count unchanged. The credit rule makes overflow impossible; a push while full is a design error, so the bench must assert it never happens.
- Reset values: state IDLE, mem_addr 0, both stage valid bits 0, FIFO empty, pix_valid 0, pix_data 0, busy 0, frame_done 0.
- Reset mid-frame: all in-flight and queued words are discarded, no frame_done is issued, and the next start begins at pixel 0.

## Timing
- start sampled at edge T → mem_addr = {frame,0} after T.
- Memory data valid after T+1.
- Word in FIFO and pix_valid=1 after T+2. First-word latency is 2 cycles.
- Steady state with pix_ready held high: one word per cycle, 64 words in cycles T+2…T+65.
- frame_done is high for the cycle after the edge on which word 63 transfers; busy falls on that same edge.
- pix_data changes only on a pop or on a push into an empty FIFO; it is stable while pix_valid && !pix_ready.

## Structure
- Package led_pkg holds:
  - PIXELS, FRAMES, FIFO_DEPTH defaults;
  - typedef grb_t (packed struct g, r, b bytes);
  - enum state_t {IDLE, FETCH, DRAIN}.
- Sub-module pixel_fifo: parameterised synchronous FWFT FIFO, width 24, depth FIFO_DEPTH, with count output. The top level holds the FSM, counters, pipeline valid bits and scaler.

## Test plan
- Full frame: frame=3, brightness=255, mask=111, pix_ready=1 → 64 words equal to {G,R,B} at addresses 192…255 in order. frame_done pulses exactly once, in the cycle after the 64th transfer.
- Scaling: constant memory value 200 with brightness 128 → each byte 100. With brightness 0 → 0x000000. With brightness 255 → 200.
- Backpressure: pix_ready=0 for 100 cycles after start → mem_addr holds pixel 3 and the FIFO holds 4 words with no overflow. pix_data stays at pixel 0's word. Releasing pix_ready yields pixels 0…63 with no gaps or duplicates.
- Mask: mask=010 with R=0x55, G=0xAA, B=0x11 → pix_data 0x005500 for all pixels.
- Control: start asserted during FETCH is ignored (the sequence is unchanged). rst asserted after pixel 20 transfers → pix_valid and busy are 0 immediately. A new start then restarts from address {frame,0}.
- Address wrap: frame=31 → last address 2047, no carry into other bits. frame_done fires and the FSM returns to IDLE.
